// File: rtl/mc14500_sequencer_pkg.sv
// Shared opcode encoding and fetch-word layout helpers for the MC14500 program sequencer.
package mc14500_sequencer_pkg;

   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned MAX_ADDR_W = 32;
   localparam int unsigned WORD_MAX_W = OPCODE_W + MAX_ADDR_W;

   typedef enum logic [OPCODE_W-1:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } instruction_t;

   // Words are passed zero-extended to WORD_MAX_W so one helper serves every ADDR_W.
   function automatic instruction_t word_opcode(input logic [WORD_MAX_W-1:0] word,
                                                input int unsigned            addr_w);
      return instruction_t'(OPCODE_W'(word >> addr_w));
   endfunction

   function automatic logic [MAX_ADDR_W-1:0] word_operand(input logic [WORD_MAX_W-1:0] word,
                                                          input int unsigned            addr_w);
      logic [MAX_ADDR_W-1:0] mask;
      mask = (addr_w >= MAX_ADDR_W) ? '1 : ((MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1));
      return word[MAX_ADDR_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/mc14500_sequencer_if.sv
// Program-memory and ICU-facing signals of the sequencer; master is the sequencer side.
interface mc14500_sequencer_if #(
   parameter int unsigned ADDR_W = 8
);
   import mc14500_sequencer_pkg::*;

   logic [ADDR_W-1:0]          prog_addr;
   logic [OPCODE_W+ADDR_W-1:0] prog_data;
   instruction_t               instruction;
   logic [ADDR_W-1:0]          io_addr;
   logic                       jmp;
   logic                       rtn;
   logic                       flag_f;
   logic                       rr_in;

   modport master (
      output prog_addr, instruction, io_addr,
      input  prog_data, jmp, rtn, flag_f, rr_in
   );

   modport slave (
      input  prog_addr, instruction, io_addr,
      output prog_data, jmp, rtn, flag_f, rr_in
   );

endinterface

// File: rtl/mc14500_sequencer_return_stack.sv
// LIFO of return addresses; overflowing pushes are dropped and empty pops read zero.
module mc14500_sequencer_return_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty,
   output logic             err_set
);
   localparam int unsigned SP_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [WIDTH-1:0] mem [2**IDX_W];

   assign full    = (sp == SP_W'(DEPTH));
   assign empty   = (sp == '0);
   assign wr_idx  = IDX_W'(sp);
   assign rd_idx  = IDX_W'(sp - SP_W'(1));
   assign top     = empty ? '0 : mem[rd_idx];
   assign err_set = (push && full) || (pop && empty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp - SP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= push_data;
      end
   end

endmodule

// File: rtl/mc14500_sequencer.sv
// Program counter, instruction register and call/return handling for the MC14500 ICU.
module mc14500_sequencer
   import mc14500_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   mc14500_sequencer_if.master bus,
   output logic                stack_err
);
   localparam int unsigned WORD_W = OPCODE_W + ADDR_W;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] ir_addr;
   logic [WORD_W-1:0] ir;
   logic              skip_q;

   instruction_t      ir_opcode;
   logic [ADDR_W-1:0] ir_operand;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] stack_top;
   logic              redirect;
   logic              push;
   logic              pop;
   logic              stack_full;
   logic              stack_empty;
   logic              stack_err_set;

   assign ir_opcode  = word_opcode(WORD_MAX_W'(ir), ADDR_W);
   assign ir_operand = ADDR_W'(word_operand(WORD_MAX_W'(ir), ADDR_W));

   // A skipped flow-control word must neither redirect nor touch the stack.
   always_comb begin
      redirect = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      target   = ir_operand;
      if (!skip_q) begin
         if (bus.jmp) begin
            redirect = 1'b1;
         end else if (bus.flag_f) begin
            redirect = 1'b1;
            push     = 1'b1;
         end else if (bus.rtn) begin
            redirect = 1'b1;
            pop      = 1'b1;
            target   = stack_top;
         end
      end
   end

   assign fetch_addr      = redirect ? target : pc;
   assign bus.prog_addr   = fetch_addr;
   assign bus.instruction = ir_opcode;
   assign bus.io_addr     = ir_operand;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= '0;
         ir        <= '0;
         ir_addr   <= '0;
         skip_q    <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         ir        <= bus.prog_data;
         ir_addr   <= fetch_addr;
         pc        <= fetch_addr + ADDR_W'(1);
         skip_q    <= skip_q ? 1'b0
                             : ((ir_opcode == RTN) || ((ir_opcode == SKZ) && !bus.rr_in));
         if (stack_err_set) begin
            stack_err <= 1'b1;
         end
      end
   end

   mc14500_sequencer_return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_W)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (ir_addr),
      .top       (stack_top),
      .full      (stack_full),
      .empty     (stack_empty),
      .err_set   (stack_err_set)
   );

   assert property (@(posedge clk) disable iff (rst) !(stack_full && stack_empty));

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench: reset, wrap, jump, call/return, skip and stack error cases.
module tb_mc14500_sequencer;
   import mc14500_sequencer_pkg::*;

   logic clk;
   logic rst;
   logic stack_err;
   logic stack_err4;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [7:0]  pa_e;
   logic [7:0]  pa_l;
   logic [3:0]  pa4;
   logic [11:0] mem  [256];
   logic [7:0]  mem4 [16];

   mc14500_sequencer_if #(.ADDR_W(8)) bus  ();
   mc14500_sequencer_if #(.ADDR_W(4)) bus4 ();

   mc14500_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stack_err (stack_err)
   );

   mc14500_sequencer #(.ADDR_W(4), .STACK_DEPTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus4),
      .stack_err (stack_err4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.prog_data  = mem[bus.prog_addr];
   assign bus4.prog_data = mem4[bus4.prog_addr];
   assign bus4.jmp       = 1'b0;
   assign bus4.rtn       = 1'b0;
   assign bus4.flag_f    = 1'b0;
   assign bus4.rr_in     = 1'b0;

   // ICU stand-in: decodes after the negedge, ignores skips so the sequencer must suppress them.
   always begin
      bus.jmp    = 1'b0;
      bus.rtn    = 1'b0;
      bus.flag_f = 1'b0;
      @(negedge clk);
      bus.jmp    = (bus.instruction == JMP);
      bus.rtn    = (bus.instruction == RTN);
      bus.flag_f = (bus.instruction == NOPF);
      @(posedge clk);
      #1;
   end

   function automatic logic [11:0] w(input instruction_t op, input logic [7:0] a);
      return {op, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_default();
      for (int i = 0; i < 256; i++) mem[i] = w(LD, 8'(i));
      for (int i = 0; i < 16; i++) mem4[i] = {LD, 4'(i)};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   // One cycle: early sample before the ICU responds, late sample once redirects are visible.
   task automatic cyc();
      @(posedge clk);
      #2 pa_e = bus.prog_addr;
      @(negedge clk);
      #1;
      pa_l = bus.prog_addr;
      pa4  = bus4.prog_addr;
   endtask

   initial begin
      rst       = 1'b1;
      bus.rr_in = 1'b0;

      // Reset and jump
      load_default();
      mem[5]     = w(JMP, 8'h20);
      mem[6]     = w(LD, 8'h66);
      mem[8'h20] = w(OR, 8'h77);
      do_reset();
      chk("rst_prog_addr", 32'(bus.prog_addr), 32'h0);
      chk("rst_instruction", 32'(bus.instruction), 32'(NOPO));
      chk("rst_io_addr", 32'(bus.io_addr), 32'h0);
      chk("rst_stack_err", 32'(stack_err), 32'h0);
      chk("rst_prog_addr4", 32'(bus4.prog_addr), 32'h0);
      cyc();
      chk("first_fetch_next", 32'(pa_l), 32'h1);
      chk("first_instr_ld", 32'(bus.instruction), 32'(LD));
      repeat (4) cyc();
      chk("jmp_pre_addr", 32'(pa_l), 32'h5);
      cyc();
      chk("jmp_early_addr", 32'(pa_e), 32'h6);
      chk("jmp_target_addr", 32'(pa_l), 32'h20);
      chk("jmp_instr", 32'(bus.instruction), 32'(JMP));
      cyc();
      chk("jmp_landed_addr", 32'(pa_l), 32'h21);
      chk("jmp_landed_instr", 32'(bus.instruction), 32'(OR));
      chk("jmp_landed_io", 32'(bus.io_addr), 32'h77);

      // Sequential wrap on the 4-bit instance
      load_default();
      do_reset();
      repeat (14) cyc();
      chk("wrap_14", 32'(pa4), 32'd14);
      cyc();
      chk("wrap_15", 32'(pa4), 32'd15);
      cyc();
      chk("wrap_0", 32'(pa4), 32'd0);
      cyc();
      chk("wrap_1", 32'(pa4), 32'd1);

      // Call and return
      load_default();
      mem[8'h10] = w(NOPF, 8'h40);
      mem[8'h41] = w(RTN, 8'h00);
      do_reset();
      repeat (16) cyc();
      chk("call_pre_addr", 32'(pa_l), 32'h10);
      cyc();
      chk("call_early_addr", 32'(pa_e), 32'h11);
      chk("call_target", 32'(pa_l), 32'h40);
      cyc();
      chk("call_body_addr", 32'(pa_l), 32'h41);
      chk("call_pushed", 32'(dut.u_stack.empty), 32'h0);
      cyc();
      chk("rtn_early_addr", 32'(pa_e), 32'h42);
      chk("rtn_target", 32'(pa_l), 32'h10);
      cyc();
      chk("rtn_skip_nopf_instr", 32'(bus.instruction), 32'(NOPF));
      chk("rtn_skip_nopf_addr", 32'(pa_l), 32'h11);
      chk("rtn_popped", 32'(dut.u_stack.empty), 32'h1);
      cyc();
      chk("rtn_resume_addr", 32'(pa_l), 32'h12);
      chk("rtn_no_second_push", 32'(dut.u_stack.empty), 32'h1);
      chk("call_stack_err", 32'(stack_err), 32'h0);

      // SKZ with rr_in=0 skips the JMP; with rr_in=1 it does not
      load_default();
      mem[0] = w(SKZ, 8'h00);
      mem[1] = w(JMP, 8'h30);
      bus.rr_in = 1'b0;
      do_reset();
      cyc();
      chk("skz0_addr1", 32'(pa_l), 32'h1);
      cyc();
      chk("skz0_jmp_skipped", 32'(pa_l), 32'h2);
      cyc();
      chk("skz0_seq", 32'(pa_l), 32'h3);
      bus.rr_in = 1'b1;
      do_reset();
      cyc();
      chk("skz1_addr1", 32'(pa_l), 32'h1);
      cyc();
      chk("skz1_jmp_taken", 32'(pa_l), 32'h30);
      cyc();
      chk("skz1_landed", 32'(pa_l), 32'h31);
      bus.rr_in = 1'b0;

      // Five nested calls overflow a four-entry stack
      load_default();
      mem[8'h00] = w(NOPF, 8'h10);
      mem[8'h10] = w(NOPF, 8'h20);
      mem[8'h20] = w(NOPF, 8'h30);
      mem[8'h30] = w(NOPF, 8'h40);
      mem[8'h40] = w(NOPF, 8'h50);
      mem[8'h50] = w(RTN, 8'h00);
      do_reset();
      cyc();
      chk("ovf_call1", 32'(pa_l), 32'h10);
      cyc();
      chk("ovf_call2", 32'(pa_l), 32'h20);
      cyc();
      chk("ovf_call3", 32'(pa_l), 32'h30);
      cyc();
      chk("ovf_call4", 32'(pa_l), 32'h40);
      cyc();
      chk("ovf_call5_taken", 32'(pa_l), 32'h50);
      chk("ovf_err_before", 32'(stack_err), 32'h0);
      cyc();
      chk("ovf_err_set", 32'(stack_err), 32'h1);
      chk("ovf_rtn_top", 32'(pa_l), 32'h30);
      cyc();
      chk("ovf_resume", 32'(pa_l), 32'h31);
      chk("ovf_err_sticky", 32'(stack_err), 32'h1);

      // RTN on an empty stack
      load_default();
      mem[0] = w(RTN, 8'h00);
      do_reset();
      chk("unf_err_cleared", 32'(stack_err), 32'h0);
      cyc();
      chk("unf_target0", 32'(pa_l), 32'h0);
      chk("unf_err_before", 32'(stack_err), 32'h0);
      cyc();
      chk("unf_skip_addr", 32'(pa_l), 32'h1);
      chk("unf_err_set", 32'(stack_err), 32'h1);
      chk("unf_sp_zero", 32'(dut.u_stack.empty), 32'h1);
      cyc();
      chk("unf_err_sticky", 32'(stack_err), 32'h1);
      chk("unf_seq", 32'(pa_l), 32'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc14500_sequencer.md
Name: mc14500_sequencer

Overview:
- Program-flow responder for the ICU.
- Owns the program counter, fetches instruction words from program memory, and presents opcode plus operand address to the ICU and I/O.
- Acts on the ICU's jmp / rtn / flag_f outputs: JMP jumps, NOPF calls, RTN returns, using an internal return stack.
- Mirrors the ICU skip rule so that skipped flow-control instructions have no effect.

Parameters:
ADDR_W, 8, program and I/O address width; the operand field width.
STACK_DEPTH, 4, number of return-stack entries (>=1).

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
prog_addr  out  ADDR_W  program memory address, combinational.
prog_data  in  4+ADDR_W  fetched word: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand; async-read memory.
instruction  out  4 (instruction_t)  opcode of the current word, to the ICU.
io_addr  out  ADDR_W  operand of the current word, to the I/O decoder.
jmp  in  1  from ICU.
rtn  in  1  from ICU.
flag_f  in  1  from ICU; a NOPF is treated as a subroutine call.
rr_in  in  1  ICU result register (rr_out).
stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- State:
  - pc (ADDR_W): next sequential fetch address.
  - ir (4+ADDR_W): current word.
  - ir_addr (ADDR_W): address ir was fetched from.
  - skip_q: mirrors the ICU skip rule.
  - Return stack and sp.
- Reset (async, while rst=1):
  - pc=0, ir={NOPO, 0}, ir_addr=0, skip_q=0, sp=0, stack_err=0.
  - instruction=NOPO, io_addr=0.
  - The first posedge after release fetches address 0.
- Outputs: instruction=ir.opcode and io_addr=ir.operand, both straight from ir.
- Redirect decision (combinational, for the word in ir; the ICU reports it after the negedge of the same cycle):
  - Not redirected when skip_q=1.
  - jmp=1: target=ir.operand.
  - flag_f=1: call. target=ir.operand; push ir_addr (the address of the NOPF itself).
  - rtn=1: target=stack top; pop.
  - Otherwise: no redirect.
- prog_addr = redirect ? target : pc.
- Each posedge: ir<=prog_data; ir_addr<=prog_addr; pc<=prog_addr+1 (mod 2^ADDR_W, wraps to 0).
- Redirects therefore take effect with zero bubbles. There is no delay slot.
- Return convention: RTN lands on the calling NOPF. The ICU skips the word after RTN, and skip_q suppresses its flag_f. Execution therefore resumes at call+1.
- skip_q update, each posedge: skip_q <= skip_q ? 0 : (ir.opcode==RTN) | (ir.opcode==SKZ & ~rr_in). This matches the ICU one-instruction skip.
- A skipped JMP/NOPF/RTN does not redirect and does not touch the stack.
- jmp, flag_f and rtn are mutually exclusive by opcode. No priority beyond listed order is required.
- Stack (LIFO, STACK_DEPTH entries):
  - Push on full: the push is dropped, stack_err<=1, and the jump is still taken.
  - Pop on empty: target=0, stack_err<=1, sp stays 0.
  - stack_err clears only on rst.
- Reset mid-operation: everything returns to reset values immediately. In-flight redirects are discarded.

Decomposition:
- Package instructions:
  - Existing instruction_t with fixed encoding NOPO=0, LD=1, LDC=2, AND=3, ANDC=4, OR=5, ORC=6, XNOR=7, STO=8, STOC=9, IEN=A, OEN=B, JMP=C, RTN=D, SKZ=E, NOPF=F.
  - Add OPCODE_W=4.
  - Add a parameterisable fetch-word layout helper (opcode/operand slice functions).
- Sub-module return_stack (push, pop, push_data, top, full, empty, err_set). The sequencer keeps pc, ir and the skip mirror.

Test Plan:
- Reset: hold rst 3 cycles, then release -> prog_addr=0, instruction=NOPO, stack_err=0. Next cycle fetches addr 0 then 1.
- Sequential wrap, ADDR_W=4: straight-line LD words -> prog_addr 14, 15, 0, 1; no stall.
- Jump: JMP 0x20 at addr 5 -> prog_addr sequence 5, 6, 0x20, 0x21. The word at 6 is fetched but is not the next ir after 0x20 is issued; no bubble after redirect.
- Call/return: NOPF 0x40 at 0x10, RTN at 0x41 ->
  - prog_addr 0x10, 0x11, 0x40, 0x41, 0x42, 0x10, 0x11, 0x12.
  - The NOPF at 0x10 is skipped, with no second push.
  - sp returns to 0.
- Skip: SKZ with rr_in=0 followed by JMP 0x30 -> no redirect, flow continues sequentially. Repeat with rr_in=1 -> jump to 0x30.
- Stack overflow/underflow: 5 nested calls with STACK_DEPTH=4 -> stack_err=1 on the 5th call, jump still taken. After reset, RTN on empty -> target 0, stack_err=1.
